// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller: funct3 codes,
// sequencer states and size/legality decoding helpers.
package data_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        RESP
    } state_t;

    // Number of byte beats for a funct3 code; 0 marks an unusable size field.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic illegal_op(input logic we, input logic [2:0] funct3);
        return (funct3[1:0] == 2'b11) || (funct3[2] && we);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic favour_one;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = favour_one ? 2'b10 : 2'b01;
        end
    end

    // After any accepted grant the other port becomes the favoured one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            favour_one <= 1'b0;
        end else if (accept && (gnt != 2'b00)) begin
            favour_one <= gnt[0];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Two-port sequencer in front of a byte-wide synchronous RAM, splitting
// word/half/byte loads and stores into little-endian byte beats.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int BYTE_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     P0_REQ,
    input  logic                     P0_WE,
    input  logic [ADDRESS_WIDTH-1:0] P0_A,
    input  logic [DATA_WIDTH-1:0]    P0_WD,
    input  logic [2:0]               P0_FUNCT3,
    input  logic                     P1_REQ,
    input  logic                     P1_WE,
    input  logic [ADDRESS_WIDTH-1:0] P1_A,
    input  logic [DATA_WIDTH-1:0]    P1_WD,
    input  logic [2:0]               P1_FUNCT3,
    output logic [1:0]               GNT,
    output logic [1:0]               DONE,
    output logic [DATA_WIDTH-1:0]    RD,
    output logic                     ERR,
    output logic                     MEM_EN,
    output logic                     MEM_WE,
    output logic [ADDRESS_WIDTH-1:0] MEM_A,
    output logic [BYTE_WIDTH-1:0]    MEM_WD,
    input  logic [BYTE_WIDTH-1:0]    MEM_RD
);

    state_t                   state;
    logic [1:0]               req, arb_gnt, beat, beat_next, last_beat;
    logic                     accept, sel, sel_we;
    logic                     owner, lat_we, lat_zext, lat_ill;
    logic [2:0]               sel_f3, lat_size;
    logic [ADDRESS_WIDTH-1:0] sel_a, lat_a;
    logic [DATA_WIDTH-1:0]    sel_wd, lat_wd, assembly, full_word, extended;

    assign req    = {P1_REQ, P0_REQ};
    assign accept = (state == IDLE);

    rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst_n  (RST_N),
        .req    (req),
        .accept (accept),
        .gnt    (arb_gnt)
    );

    assign sel       = arb_gnt[1];
    assign sel_we    = sel ? P1_WE     : P0_WE;
    assign sel_a     = sel ? P1_A      : P0_A;
    assign sel_wd    = sel ? P1_WD     : P0_WD;
    assign sel_f3    = sel ? P1_FUNCT3 : P0_FUNCT3;
    assign beat_next = beat + 2'd1;
    assign last_beat = 2'(lat_size - 3'd1);

    // The final load byte arrives during DRAIN, so merge it in before extending.
    always_comb begin
        full_word = assembly;
        full_word[BYTE_WIDTH*int'(last_beat) +: BYTE_WIDTH] = MEM_RD;
        extended = full_word;
        case (lat_size)
            3'd1: extended = {{(DATA_WIDTH-BYTE_WIDTH){!lat_zext & full_word[BYTE_WIDTH-1]}},
                              full_word[BYTE_WIDTH-1:0]};
            3'd2: extended = {{(DATA_WIDTH-2*BYTE_WIDTH){!lat_zext & full_word[2*BYTE_WIDTH-1]}},
                              full_word[2*BYTE_WIDTH-1:0]};
            default: extended = full_word;
        endcase
    end

    // Illegal codes skip ACCESS but still pass through DRAIN, keeping
    // every transaction at N+2 cycles with N=0 for the illegal case.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            GNT      <= 2'b00;
            DONE     <= 2'b00;
            RD       <= '0;
            ERR      <= 1'b0;
            MEM_EN   <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_A    <= '0;
            MEM_WD   <= '0;
            beat     <= 2'd0;
            owner    <= 1'b0;
            lat_we   <= 1'b0;
            lat_zext <= 1'b0;
            lat_ill  <= 1'b0;
            lat_size <= 3'd0;
            lat_a    <= '0;
            lat_wd   <= '0;
            assembly <= '0;
        end else begin
            DONE   <= 2'b00;
            RD     <= '0;
            ERR    <= 1'b0;
            MEM_EN <= 1'b0;
            MEM_WE <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        GNT      <= arb_gnt;
                        owner    <= sel;
                        lat_we   <= sel_we;
                        lat_zext <= sel_f3[2];
                        lat_ill  <= illegal_op(sel_we, sel_f3);
                        lat_size <= size_bytes(sel_f3);
                        lat_a    <= sel_a;
                        lat_wd   <= sel_wd;
                        beat     <= 2'd0;
                        assembly <= '0;
                        if (illegal_op(sel_we, sel_f3)) begin
                            state <= DRAIN;
                        end else begin
                            state  <= ACCESS;
                            MEM_EN <= 1'b1;
                            MEM_WE <= sel_we;
                            MEM_A  <= sel_a;
                            MEM_WD <= sel_wd[BYTE_WIDTH-1:0];
                        end
                    end
                end
                ACCESS: begin
                    if (!lat_we && (beat != 2'd0)) begin
                        assembly[BYTE_WIDTH*(int'(beat)-1) +: BYTE_WIDTH] <= MEM_RD;
                    end
                    if (beat == last_beat) begin
                        state <= DRAIN;
                    end else begin
                        beat   <= beat_next;
                        MEM_EN <= 1'b1;
                        MEM_WE <= lat_we;
                        MEM_A  <= lat_a + ADDRESS_WIDTH'(beat_next);
                        MEM_WD <= lat_wd[BYTE_WIDTH*int'(beat_next) +: BYTE_WIDTH];
                    end
                end
                DRAIN: begin
                    state <= RESP;
                    DONE  <= owner ? 2'b10 : 2'b01;
                    ERR   <= lat_ill;
                    RD    <= (lat_we || lat_ill) ? '0 : extended;
                end
                RESP: begin
                    state <= IDLE;
                    GNT   <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a byte RAM model.
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    logic        clk = 1'b0;
    logic        RST_N;
    logic        P0_REQ, P0_WE, P1_REQ, P1_WE;
    logic [8:0]  P0_A, P1_A;
    logic [31:0] P0_WD, P1_WD;
    logic [2:0]  P0_FUNCT3, P1_FUNCT3;
    logic [1:0]  GNT, DONE;
    logic [31:0] RD;
    logic        ERR, MEM_EN, MEM_WE;
    logic [8:0]  MEM_A;
    logic [7:0]  MEM_WD, mem_rd;

    logic [7:0]  mem [512];
    logic [8:0]  en_log[$];
    logic [8:0]  wr_a[$];
    logic [7:0]  wr_d[$];
    logic        clr = 1'b1;

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          en_base, wr_base;
    logic [31:0] res_rd;
    logic        res_err;
    logic [1:0]  res_done;
    int          res_lat;

    always #5 clk = ~clk;

    data_mem_ctrl dut (
        .CLK       (clk),
        .RST_N     (RST_N),
        .P0_REQ    (P0_REQ),
        .P0_WE     (P0_WE),
        .P0_A      (P0_A),
        .P0_WD     (P0_WD),
        .P0_FUNCT3 (P0_FUNCT3),
        .P1_REQ    (P1_REQ),
        .P1_WE     (P1_WE),
        .P1_A      (P1_A),
        .P1_WD     (P1_WD),
        .P1_FUNCT3 (P1_FUNCT3),
        .GNT       (GNT),
        .DONE      (DONE),
        .RD        (RD),
        .ERR       (ERR),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_A     (MEM_A),
        .MEM_WD    (MEM_WD),
        .MEM_RD    (mem_rd)
    );

    // Byte RAM with one-cycle read latency, logging every access
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            mem_rd <= 8'h00;
        end else if (MEM_EN) begin
            en_log.push_back(MEM_A);
            if (MEM_WE) begin
                mem[MEM_A] <= MEM_WD;
                wr_a.push_back(MEM_A);
                wr_d.push_back(MEM_WD);
            end else begin
                mem_rd <= mem[MEM_A];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction on one port; inputs are scrambled after grant
    task automatic applyStimulus(input logic port, input logic we, input logic [8:0] a,
                                 input logic [31:0] wd, input logic [2:0] f3);
        int n;
        bit got;
        @(negedge clk);
        en_base = en_log.size();
        wr_base = wr_a.size();
        if (!port) begin
            P0_REQ = 1'b1; P0_WE = we; P0_A = a; P0_WD = wd; P0_FUNCT3 = f3;
        end else begin
            P1_REQ = 1'b1; P1_WE = we; P1_A = a; P1_WD = wd; P1_FUNCT3 = f3;
        end
        @(posedge clk);
        n = 0;
        got = 1'b0;
        res_done = 2'b00; res_rd = 32'h0; res_err = 1'b0; res_lat = 0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                P0_A = ~P0_A; P0_WD = ~P0_WD; P1_A = ~P1_A; P1_WD = ~P1_WD;
            end
            if (DONE != 2'b00) begin
                got = 1'b1;
                res_done = DONE; res_rd = RD; res_err = ERR; res_lat = n;
            end
        end
        P0_REQ = 1'b0;
        P1_REQ = 1'b0;
        if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        RST_N = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        RST_N = 1'b1;
    endtask

    initial begin : main
        int dones, bad_gnt, both_done, seen;
        logic [1:0] exp_g;
        RST_N = 1'b0;
        P0_REQ = 1'b0; P0_WE = 1'b0; P0_A = '0; P0_WD = '0; P0_FUNCT3 = '0;
        P1_REQ = 1'b0; P1_WE = 1'b0; P1_A = '0; P1_WD = '0; P1_FUNCT3 = '0;
        @(posedge clk);
        clr = 1'b0;
        doReset();

        checkOutput("reset_ctrl", {26'd0, GNT, DONE, ERR, MEM_EN, MEM_WE}, 32'd0);
        checkOutput("reset_rd", RD, 32'd0);
        checkOutput("reset_mem_a_wd", {15'd0, MEM_A, MEM_WD}, 32'd0);

        // sw then lw of a full word
        applyStimulus(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, SW);
        checkOutput("sw_wr_count", wr_a.size() - wr_base, 32'd4);
        checkOutput("sw_wr_addr", {5'd0, wr_a[wr_base][2:0], wr_a[wr_base+1][2:0],
                    wr_a[wr_base+2][2:0], wr_a[wr_base+3][2:0], wr_a[wr_base]}, {5'd0, 12'o0123, 9'h010});
        checkOutput("sw_wr_data", {wr_d[wr_base+3], wr_d[wr_base+2], wr_d[wr_base+1], wr_d[wr_base]}, 32'hDEADBEEF);
        checkOutput("sw_rd_zero", res_rd, 32'd0);
        checkOutput("sw_latency", res_lat, 32'd6);
        applyStimulus(1'b0, 1'b0, 9'h010, 32'h0, LW);
        checkOutput("lw_rd", res_rd, 32'hDEADBEEF);
        checkOutput("lw_latency", res_lat, 32'd6);
        checkOutput("lw_done", {30'd0, res_done}, 32'd1);

        // byte/half sign handling and neighbour preservation
        applyStimulus(1'b1, 1'b1, 9'h020, 32'h12345680, SB);
        applyStimulus(1'b1, 1'b1, 9'h021, 32'h00000055, SB);
        applyStimulus(1'b1, 1'b1, 9'h022, 32'hFFFFFF66, SB);
        checkOutput("sb_wr_count", wr_a.size() - wr_base, 32'd1);
        applyStimulus(1'b0, 1'b0, 9'h020, 32'h0, LB);
        checkOutput("lb_rd", res_rd, 32'hFFFFFF80);
        checkOutput("lb_latency", res_lat, 32'd3);
        applyStimulus(1'b0, 1'b0, 9'h020, 32'h0, LBU);
        checkOutput("lbu_rd", res_rd, 32'h00000080);
        applyStimulus(1'b0, 1'b1, 9'h021, 32'hAAAAAA7F, SB);
        applyStimulus(1'b0, 1'b0, 9'h020, 32'h0, LH);
        checkOutput("lh_rd", res_rd, 32'h00007F80);
        checkOutput("lh_latency", res_lat, 32'd4);
        applyStimulus(1'b0, 1'b0, 9'h022, 32'h0, LBU);
        checkOutput("neighbour_kept", res_rd, 32'h00000066);

        // address wrap across the top of the RAM
        applyStimulus(1'b1, 1'b1, 9'h1FF, 32'h00000034, SB);
        applyStimulus(1'b1, 1'b1, 9'h000, 32'h00000012, SB);
        applyStimulus(1'b0, 1'b0, 9'h1FF, 32'h0, LH);
        checkOutput("wrap_addr0", {23'd0, en_log[en_base]}, 32'h1FF);
        checkOutput("wrap_addr1", {23'd0, en_log[en_base+1]}, 32'h000);
        checkOutput("wrap_rd", res_rd, 32'h00001234);
        checkOutput("wrap_err", {31'd0, res_err}, 32'd0);

        // illegal codes on port 1
        applyStimulus(1'b1, 1'b0, 9'h030, 32'h0, 3'b011);
        checkOutput("ill_load_done", {30'd0, res_done}, 32'd2);
        checkOutput("ill_load_err_rd", {res_rd[30:0], res_err}, 32'd1);
        checkOutput("ill_load_noaccess", en_log.size() - en_base, 32'd0);
        checkOutput("ill_load_latency", res_lat, 32'd2);
        applyStimulus(1'b1, 1'b1, 9'h030, 32'hFFFFFFFF, 3'b100);
        checkOutput("ill_store_done", {30'd0, res_done}, 32'd2);
        checkOutput("ill_store_err_rd", {res_rd[30:0], res_err}, 32'd1);
        checkOutput("ill_store_noaccess", en_log.size() - en_base, 32'd0);
        checkOutput("ill_store_latency", res_lat, 32'd2);

        // both ports requesting continuously from reset
        @(negedge clk);
        RST_N = 1'b0;
        P0_REQ = 1'b1; P0_WE = 1'b0; P0_A = 9'h010; P0_FUNCT3 = LW;
        P1_REQ = 1'b1; P1_WE = 1'b0; P1_A = 9'h020; P1_FUNCT3 = LW;
        repeat (2) @(posedge clk);
        @(negedge clk);
        RST_N = 1'b1;
        dones = 0; bad_gnt = 0; both_done = 0;
        for (int c = 0; c < 80 && dones < 4; c++) begin
            @(negedge clk);
            if (MEM_EN && GNT != 2'b01 && GNT != 2'b10) bad_gnt++;
            if (DONE == 2'b11) both_done++;
            if (DONE != 2'b00) begin
                exp_g = dones[0] ? 2'b10 : 2'b01;
                checkOutput($sformatf("rr_gnt%0d", dones), {30'd0, GNT}, {30'd0, exp_g});
                checkOutput($sformatf("rr_done%0d", dones), {30'd0, DONE}, {30'd0, exp_g});
                checkOutput($sformatf("rr_rd%0d", dones), RD, dones[0] ? 32'h00667F80 : 32'hDEADBEEF);
                dones++;
            end
        end
        P0_REQ = 1'b0;
        P1_REQ = 1'b0;
        checkOutput("rr_done_count", dones, 32'd4);
        checkOutput("rr_gnt_overlap", bad_gnt, 32'd0);
        checkOutput("rr_double_done", both_done, 32'd0);
        repeat (6) @(posedge clk);

        // reset during the second beat of a store
        applyStimulus(1'b1, 1'b1, 9'h040, 32'hAAAAAAAA, SW);
        @(negedge clk);
        P0_REQ = 1'b1; P0_WE = 1'b1; P0_A = 9'h040; P0_WD = 32'h11223344; P0_FUNCT3 = SW;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        RST_N = 1'b0;
        P0_REQ = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ctrl", {26'd0, GNT, DONE, ERR, MEM_EN, MEM_WE}, 32'd0);
        checkOutput("midrst_rd", RD, 32'd0);
        checkOutput("midrst_mem_a_wd", {15'd0, MEM_A, MEM_WD}, 32'd0);
        RST_N = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (DONE != 2'b00) seen++;
        end
        checkOutput("midrst_no_done", seen, 32'd0);
        applyStimulus(1'b0, 1'b0, 9'h040, 32'h0, LW);
        checkOutput("midrst_partial_bytes", res_rd, 32'hAAAA3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
